// File: rtl/snn_weight_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package  : snn_wload_pkg
// Purpose  : Shared state encoding and default geometry for snn_weight_loader.
// Revision : 1.0
// ============================================================================
package snn_wload_pkg;

    localparam int c_DEF_LAYERS = 4;
    localparam int c_DEF_ADDR_W = 13;
    localparam int c_DEF_DW     = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_LOAD  = 3'd2,
        S_NEXT  = 3'd3,
        S_DONE  = 3'd4
    } wload_state_e;

endpackage : snn_wload_pkg
`default_nettype wire

// File: rtl/snn_weight_loader_if.sv
`default_nettype none
// ============================================================================
// Interface: snn_weight_loader_if
// Purpose  : Flash stream handshake plus weight-memory write bus.
// Revision : 1.0
// ============================================================================
interface snn_weight_loader_if
    import snn_wload_pkg::*;
#(
    parameter int LAYERS = c_DEF_LAYERS,
    parameter int ADDR_W = c_DEF_ADDR_W,
    parameter int DW     = c_DEF_DW
);

    logic              i_fl_valid;
    logic [DW-1:0]     i_fl_dat;
    logic              o_fl_ready;
    logic [LAYERS-1:0] o_snn_we;
    logic [ADDR_W-1:0] o_snn_adr;
    logic [DW-1:0]     o_snn_dat;

    // Loader side
    modport slave (
        input  i_fl_valid,
        input  i_fl_dat,
        output o_fl_ready,
        output o_snn_we,
        output o_snn_adr,
        output o_snn_dat
    );

    // Flash source / memory side
    modport master (
        output i_fl_valid,
        output i_fl_dat,
        input  o_fl_ready,
        input  o_snn_we,
        input  o_snn_adr,
        input  o_snn_dat
    );

endinterface : snn_weight_loader_if
`default_nettype wire

// File: rtl/snn_weight_loader_addr_cnt.sv
`default_nettype none
// ============================================================================
// Module   : wload_addr_cnt
// Purpose  : ADDR_W+1 bit address/word counter with clear, enable and
//            terminal-count compare against the active layer count.
// Revision : 1.0
// ============================================================================
module wload_addr_cnt
    import snn_wload_pkg::*;
#(
    parameter int ADDR_W = c_DEF_ADDR_W
) (
    input  wire                wb_clk,
    input  wire                wb_rst_n,
    input  wire                i_clr,
    input  wire                i_en,
    input  wire [ADDR_W:0]     i_limit,
    output logic [ADDR_W-1:0]  o_adr,
    output logic               o_last
);

    logic [ADDR_W:0] r_cnt;

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Extra counter bit lets a full-depth layer reach 2^ADDR_W without wrapping
    assign o_adr  = r_cnt[ADDR_W-1:0];
    assign o_last = ((r_cnt + 1'b1) == i_limit);

endmodule : wload_addr_cnt
`default_nettype wire

// File: rtl/snn_weight_loader.sv
`default_nettype none
// ============================================================================
// Module   : snn_weight_loader
// Purpose  : Streams flash words into per-layer SNN weight memories.
//            Running write checksum enabled by macro WLOAD_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module snn_weight_loader
    import snn_wload_pkg::*;
#(
    parameter int LAYERS = c_DEF_LAYERS,
    parameter int ADDR_W = c_DEF_ADDR_W,
    parameter int DW     = c_DEF_DW
) (
    input  wire                          wb_clk,
    input  wire                          wb_rst_n,
    input  wire                          i_start,
    input  wire                          i_abort,
    input  wire [LAYERS*(ADDR_W+1)-1:0]  i_count,
    snn_weight_loader_if.slave           bus,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_err,
    output logic [DW-1:0]                o_checksum
);

    localparam int              c_CW      = ADDR_W + 1;
    localparam int              c_IDX_W   = $clog2(LAYERS + 1);
    localparam logic [c_CW-1:0] c_MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

    wload_state_e       r_state;
    logic [c_CW-1:0]    r_cnt_q [LAYERS];
    logic [c_IDX_W-1:0] r_idx;
    logic [c_IDX_W-1:0] r_layer;
    logic               r_fl_ready;
    logic [LAYERS-1:0]  r_we;
    logic [ADDR_W-1:0]  r_adr;
    logic [DW-1:0]      r_dat;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic               w_accept;
    logic               w_start;
    logic               w_cnt_clr;
    logic               w_last;
    logic [ADDR_W-1:0]  w_adr;
    logic [c_CW-1:0]    w_limit;
    logic [LAYERS-1:0]  w_we_vec;
    logic               w_cfg_bad;
    logic               w_found;
    logic [c_IDX_W-1:0] w_next_layer;

    assign w_accept  = bus.i_fl_valid && r_fl_ready;
    assign w_start   = (r_state == S_IDLE) && i_start && !i_abort;
    assign w_cnt_clr = (r_state == S_NEXT);

    // NEXT resolves the next non-empty layer in a single cycle
    always_comb begin
        w_cfg_bad    = 1'b0;
        w_limit      = '0;
        w_we_vec     = '0;
        w_found      = 1'b0;
        w_next_layer = c_IDX_W'(LAYERS);
        for (int i = LAYERS - 1; i >= 0; i--) begin
            if (r_cnt_q[i] > c_MAX_CNT) begin
                w_cfg_bad = 1'b1;
            end
            if (r_layer == c_IDX_W'(i)) begin
                w_limit     = r_cnt_q[i];
                w_we_vec[i] = 1'b1;
            end
            if ((c_IDX_W'(i) >= r_idx) && (r_cnt_q[i] != '0)) begin
                w_found      = 1'b1;
                w_next_layer = c_IDX_W'(i);
            end
        end
    end

    wload_addr_cnt #(
        .ADDR_W (ADDR_W)
    ) u_addr_cnt (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .i_clr    (w_cnt_clr),
        .i_en     (w_accept),
        .i_limit  (w_limit),
        .o_adr    (w_adr),
        .o_last   (w_last)
    );

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_layer    <= '0;
            r_fl_ready <= 1'b0;
            r_we       <= '0;
            r_adr      <= '0;
            r_dat      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            for (int i = 0; i < LAYERS; i++) begin
                r_cnt_q[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            // A word taken on this edge is written even if abort also lands here
            r_we   <= w_accept ? w_we_vec : '0;
            if (w_accept) begin
                r_adr <= w_adr;
                r_dat <= bus.i_fl_dat;
            end

            if ((r_state != S_IDLE) && i_abort) begin
                r_state    <= S_IDLE;
                r_fl_ready <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            for (int i = 0; i < LAYERS; i++) begin
                                r_cnt_q[i] <= i_count[i*c_CW +: c_CW];
                            end
                            r_state <= S_CHECK;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_CHECK: begin
                        if (w_cfg_bad) begin
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= '0;
                            r_state <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        if (w_found) begin
                            r_layer    <= w_next_layer;
                            r_fl_ready <= 1'b1;
                            r_state    <= S_LOAD;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                    S_LOAD: begin
                        if (w_accept && w_last) begin
                            r_fl_ready <= 1'b0;
                            r_idx      <= r_layer + 1'b1;
                            r_state    <= S_NEXT;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state    <= S_IDLE;
                        r_fl_ready <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef WLOAD_CHECKSUM_EN
    logic [DW-1:0] r_checksum;

    // Sum lines up with o_snn_dat: it already includes the word being written
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            r_checksum <= '0;
        end else if (w_start) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + bus.i_fl_dat;
        end
    end

    assign o_checksum = r_checksum;
`else
    assign o_checksum = '0;
`endif

    assign bus.o_fl_ready = r_fl_ready;
    assign bus.o_snn_we   = r_we;
    assign bus.o_snn_adr  = r_adr;
    assign bus.o_snn_dat  = r_dat;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_err          = r_err;

endmodule : snn_weight_loader
`default_nettype wire

// File: tb/tb_snn_weight_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_snn_weight_loader
// Purpose  : Randomised self-checking bench for snn_weight_loader against a
//            flattened per-layer write-order model.
// Revision : 1.0
// ============================================================================
module tb_snn_weight_loader;
    import snn_wload_pkg::*;

    localparam int LAYERS = 4;
    localparam int ADDR_W = 13;
    localparam int DW     = 16;
    localparam int CW     = ADDR_W + 1;
`ifdef WLOAD_CHECKSUM_EN
    localparam bit c_CSUM = 1'b1;
`else
    localparam bit c_CSUM = 1'b0;
`endif

    logic                wb_clk;
    logic                wb_rst_n;
    logic                i_start;
    logic                i_abort;
    logic [LAYERS*CW-1:0] i_count;
    logic                o_busy;
    logic                o_done;
    logic                o_err;
    logic [DW-1:0]       o_checksum;

    snn_weight_loader_if #(.LAYERS(LAYERS), .ADDR_W(ADDR_W), .DW(DW)) bus ();

    snn_weight_loader #(.LAYERS(LAYERS), .ADDR_W(ADDR_W), .DW(DW)) dut (
        .wb_clk     (wb_clk),
        .wb_rst_n   (wb_rst_n),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .i_count    (i_count),
        .bus        (bus),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_checksum (o_checksum)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    typedef struct {
        int layer;
        int adr;
    } wr_t;

    wr_t           flat[$];
    logic [DW-1:0] stream[$];
    int            n_vec  = 0;
    int            n_miss = 0;
    int            cyc    = 0;
    int            wr_cnt = 0;
    int            n_done = 0;
    int            n_errp = 0;
    logic [DW-1:0] sum_model = '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock: handshake sampled mid-cycle, outputs checked just after the edge
    task automatic tick();
        logic          hs;
        logic          rs;
        logic [DW-1:0] d;
        @(negedge wb_clk);
        hs = bus.i_fl_valid && bus.o_fl_ready;
        rs = wb_rst_n;
        d  = bus.i_fl_dat;
        @(posedge wb_clk);
        #1;
        cyc++;
        if (hs && rs) begin
            if (wr_cnt < flat.size()) begin
                check_eq("we",  32'(bus.o_snn_we),  32'(1) << flat[wr_cnt].layer);
                check_eq("adr", 32'(bus.o_snn_adr), 32'(flat[wr_cnt].adr));
                check_eq("dat", 32'(bus.o_snn_dat), 32'(d));
            end else begin
                check_eq("xs_accept", 32'(wr_cnt + 1), 32'(flat.size()));
            end
            sum_model = sum_model + d;
            wr_cnt++;
            if (stream.size() > 0) void'(stream.pop_front());
        end else begin
            check_eq("we_idle", 32'(bus.o_snn_we), 32'd0);
        end
        if (o_done) n_done++;
        if (o_err)  n_errp++;
        bus.i_fl_dat = (stream.size() > 0) ? stream[0] : DW'(16'hDEAD);
    endtask

    task automatic run_load(input int c0, input int c1, input int c2, input int c3,
                            input int vmode, input bit seq_dat,
                            input int kill_at, input bit kill_rst, input int restart_at);
        int c[LAYERS];
        int total;
        bit bad;
        bit finished;
        bit killed;
        bit restarted;
        bit v;
        int t0;
        int t_fin;
        int budget;
        c = '{c0, c1, c2, c3};
        flat.delete();
        stream.delete();
        total = 0;
        bad   = 1'b0;
        for (int l = 0; l < LAYERS; l++) if (c[l] > (1 << ADDR_W)) bad = 1'b1;
        if (!bad) begin
            for (int l = 0; l < LAYERS; l++) begin
                for (int a = 0; a < c[l]; a++) begin
                    flat.push_back('{layer: l, adr: a});
                    total++;
                end
            end
        end
        for (int k = 0; k < total + 3; k++) stream.push_back(seq_dat ? DW'(k + 1) : DW'($urandom));
        wr_cnt    = 0;
        n_done    = 0;
        n_errp    = 0;
        sum_model = '0;

        i_count        = {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
        bus.i_fl_dat   = stream[0];
        bus.i_fl_valid = 1'b1;
        i_start        = 1'b1;
        tick();
        i_start = 1'b0;
        t0      = cyc;

        budget    = total * 8 + 64;
        finished  = 1'b0;
        killed    = 1'b0;
        restarted = 1'b0;
        t_fin     = -1;
        for (int k = 0; k < budget && !finished; k++) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (k % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (kill_at >= 0 && wr_cnt == kill_at) begin
                killed = 1'b1;
                if (kill_rst) wb_rst_n = 1'b0;
                else begin
                    i_abort = 1'b1;
                    v       = 1'b0;
                end
            end
            if (restart_at >= 0 && wr_cnt == restart_at && !restarted && !killed) begin
                restarted = 1'b1;
                i_start   = 1'b1;
                i_count   = '1;
            end
            bus.i_fl_valid = v;
            tick();
            i_start = 1'b0;
            i_abort = 1'b0;
            if (killed) finished = 1'b1;
            if (n_done > 0 || n_errp > 0) begin
                finished = 1'b1;
                t_fin    = cyc - t0;
            end
        end
        check_eq("finish", 32'(finished), 32'd1);

        if (killed && kill_rst) begin
            check_eq("rst_ready", 32'(bus.o_fl_ready), 32'd0);
            check_eq("rst_adr",   32'(bus.o_snn_adr),  32'd0);
            check_eq("rst_dat",   32'(bus.o_snn_dat),  32'd0);
            check_eq("rst_busy",  32'(o_busy),         32'd0);
            check_eq("rst_csum",  32'(o_checksum),     32'd0);
            wb_rst_n = 1'b1;
        end
        if (killed && !kill_rst) check_eq("abort_busy", 32'(o_busy), 32'd0);

        bus.i_fl_valid = 1'b1;
        repeat (3) tick();
        bus.i_fl_valid = 1'b0;

        check_eq("ndone",    32'(n_done), 32'(!bad && !killed));
        check_eq("nerr",     32'(n_errp), 32'(bad));
        check_eq("busy_end", 32'(o_busy), 32'd0);
        if (killed) begin
            check_eq("nwr_kill", 32'(wr_cnt), 32'(kill_at));
        end else begin
            check_eq("nwr",  32'(wr_cnt),        32'(total));
            check_eq("left", 32'(stream.size()), 32'd3);
        end
        check_eq("csum", 32'(o_checksum),
                 (c_CSUM && !(killed && kill_rst)) ? 32'(sum_model) : 32'd0);
        if (bad) check_eq("err_lat", 32'(t_fin), 32'd1);
        if (!bad && total == 0 && !killed) check_eq("done_lat", 32'(t_fin), 32'd2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r[LAYERS];
        int tot;
        int ka;
        bit kr;
        wb_rst_n       = 1'b0;
        i_start        = 1'b0;
        i_abort        = 1'b0;
        i_count        = '0;
        bus.i_fl_valid = 1'b0;
        bus.i_fl_dat   = '0;
        repeat (3) tick();
        check_eq("rst_ready", 32'(bus.o_fl_ready), 32'd0);
        check_eq("rst_we",    32'(bus.o_snn_we),   32'd0);
        check_eq("rst_adr",   32'(bus.o_snn_adr),  32'd0);
        check_eq("rst_dat",   32'(bus.o_snn_dat),  32'd0);
        check_eq("rst_busy",  32'(o_busy),         32'd0);
        check_eq("rst_done",  32'(o_done),         32'd0);
        check_eq("rst_err",   32'(o_err),          32'd0);
        check_eq("rst_csum",  32'(o_checksum),     32'd0);
        wb_rst_n = 1'b1;
        tick();

        // abort wins over a simultaneous start in IDLE
        i_count = {CW'(0), CW'(0), CW'(0), CW'(2)};
        i_abort = 1'b1;
        i_start = 1'b1;
        tick();
        i_abort = 1'b0;
        i_start = 1'b0;
        check_eq("abort_start_busy", 32'(o_busy), 32'd0);
        tick();
        check_eq("abort_start_busy2", 32'(o_busy), 32'd0);

        run_load(3, 0, 2, 0,    0, 1'b1, -1, 1'b0, -1);
        run_load(0, 8193, 0, 0, 0, 1'b0, -1, 1'b0, -1);
        run_load(4, 0, 0, 0,    1, 1'b0, -1, 1'b0, -1);
        run_load(5, 0, 0, 0,    0, 1'b0,  2, 1'b0, -1);
        run_load(5, 0, 0, 0,    0, 1'b0, -1, 1'b0, -1);
        run_load(6, 0, 0, 0,    0, 1'b0,  2, 1'b1, -1);
        run_load(3, 0, 2, 0,    2, 1'b0, -1, 1'b0,  1);
        run_load(0, 0, 0, 0,    0, 1'b0, -1, 1'b0, -1);
        run_load(1, 1, 1, 8193, 0, 1'b0, -1, 1'b0, -1);
        run_load(0, 0, 0, 8192, 0, 1'b0, -1, 1'b0, -1);

        for (int it = 0; it < 16; it++) begin
            tot = 0;
            for (int l = 0; l < LAYERS; l++) begin
                r[l] = int'($urandom_range(0, 5));
                tot += r[l];
            end
            ka = -1;
            kr = 1'b0;
            if (tot > 0 && $urandom_range(0, 3) == 0) begin
                ka = int'($urandom_range(0, tot - 1));
                kr = 1'($urandom_range(0, 1));
            end
            run_load(r[0], r[1], r[2], r[3], int'($urandom_range(0, 2)), 1'b0, ka, kr, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_snn_weight_loader
`default_nettype wire
